// File: rtl/lemming_world.sv
// Terrain/environment model driving a Lemmings walker FSM: pits, digging, walls, falls, splat.
// Outputs ground/bump are combinational from pos; state updates take one cycle. No backpressure.
// Optional step counter: define LEMMING_WORLD_STEP_CNT_EN.
module lemming_world #(
  parameter int WIDTH      = 16,
  parameter int START_POS  = 8,
  parameter int DIG_CYCLES = 4,
  parameter int DIG_DEPTH  = 3,
  parameter int SPLAT_LEN  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        map_we,
  input  logic [3:0]  map_addr,
  input  logic [4:0]  map_wdata,
  input  logic        walk_left,
  input  logic        walk_right,
  input  logic        aaah,
  input  logic        digging,
  output logic        ground,
  output logic        bump_left,
  output logic        bump_right,
  output logic [3:0]  pos,
  output logic [4:0]  fall_len,
  output logic        splat,
  output logic [15:0] step_cnt
);

  localparam int DCW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

  logic [4:0]     depth_q [WIDTH];
  logic [4:0]     depth_d [WIDTH];
  logic [3:0]     pos_q, pos_d;
  logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
  logic [4:0]     fall_len_q, fall_len_d;
  logic           splat_q, splat_d;
  logic [4:0]     cur_depth;
  logic           walk_one;
  logic           moved;

  assign cur_depth  = depth_q[pos_q];
  assign walk_one   = walk_left ^ walk_right;
  assign ground     = (cur_depth == 5'd0);
  assign bump_left  = walk_left  && !walk_right && (pos_q == 4'd0);
  assign bump_right = walk_right && !walk_left  && (pos_q == 4'(WIDTH-1));
  assign pos        = pos_q;
  assign fall_len   = fall_len_q;
  assign splat      = splat_q;

  always_comb begin
    depth_d    = depth_q;
    pos_d      = pos_q;
    dig_cnt_d  = dig_cnt_q;
    fall_len_d = fall_len_q;
    splat_d    = splat_q;
    moved      = 1'b0;

    // External write first so a same-column fall/dig update overrides it.
    if (map_we && (int'(map_addr) < WIDTH))
      depth_d[map_addr] = map_wdata;

    if (cur_depth != 5'd0) begin
      depth_d[pos_q] = cur_depth - 5'd1;
      dig_cnt_d      = '0;
    end else if (digging) begin
      if (dig_cnt_q == DCW'(DIG_CYCLES-1)) begin
        depth_d[pos_q] = 5'(DIG_DEPTH);
        dig_cnt_d      = '0;
      end else begin
        dig_cnt_d = dig_cnt_q + 1'b1;
      end
    end else begin
      dig_cnt_d = '0;
      if (walk_one) begin
        if (walk_left && pos_q != 4'd0) begin
          pos_d = pos_q - 4'd1;
          moved = 1'b1;
        end else if (walk_right && pos_q != 4'(WIDTH-1)) begin
          pos_d = pos_q + 4'd1;
          moved = 1'b1;
        end
      end
    end

    if (!ground) begin
      if (fall_len_q != 5'd31)
        fall_len_d = fall_len_q + 5'd1;
    end else begin
      if (int'(fall_len_q) > SPLAT_LEN)
        splat_d = 1'b1;
      fall_len_d = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++)
        depth_q[i] <= 5'd0;
      pos_q      <= 4'(START_POS);
      dig_cnt_q  <= '0;
      fall_len_q <= 5'd0;
      splat_q    <= 1'b0;
    end else begin
      depth_q    <= depth_d;
      pos_q      <= pos_d;
      dig_cnt_q  <= dig_cnt_d;
      fall_len_q <= fall_len_d;
      splat_q    <= splat_d;
    end
  end

  logic unused_inputs;

`ifdef LEMMING_WORLD_STEP_CNT_EN
  logic [15:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (moved)
      step_cnt_d = step_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      step_cnt_q <= 16'd0;
    else
      step_cnt_q <= step_cnt_d;
  end

  assign step_cnt      = step_cnt_q;
  assign unused_inputs = aaah;
`else
  assign step_cnt      = 16'd0;
  // The lemming's scream carries no information the terrain needs.
  assign unused_inputs = aaah ^ moved;
`endif

endmodule

// File: doc/lemming_world.md
# lemming_world

Environment model for the Lemmings walker FSM, used as the stimulus end of that interface in FSM-practice benches and demos. It consumes the lemming's Moore outputs (walk_left, walk_right, aaah, digging) and generates its inputs (bump_left, bump_right, ground) from a 1-D terrain of columns with per-column pit depths. It also tracks the lemming position, fall length and splat status.

## Interface
Parameters:
- WIDTH, 16: number of terrain columns; column indices run 0..WIDTH-1.
- START_POS, 8: lemming column after reset.
- DIG_CYCLES, 4: consecutive grounded digging cycles needed to open a pit.
- DIG_DEPTH, 3: pit depth created by a completed dig.
- SPLAT_LEN, 20: a fall longer than this many cycles is fatal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- map_we  in  1  terrain write strobe.
- map_addr  in  4  column written.
- map_wdata  in  5  pit depth written; 0 = solid floor.
- walk_left, walk_right, aaah, digging  in  1 each  lemming outputs.
- ground  out  1  floor present under the lemming.
- bump_left, bump_right  out  1 each  wall contact.
- pos  out  4  current column.
- fall_len  out  5  consecutive ground=0 cycles, saturating at 31.
- splat  out  1  sticky fatal-landing flag.
- step_cnt  out  16  completed moves; present only with the macro described under Configuration.

## Operation
- Terrain: depth[0..WIDTH-1], 5 bits each.
- Combinational outputs:
  - ground = (depth[pos] == 0).
  - bump_left = walk_left && pos == 0.
  - bump_right = walk_right && pos == WIDTH-1.
- Per-cycle update, in priority order:
  1. Fall: if depth[pos] != 0, then depth[pos] <= depth[pos]-1, pos holds and dig_cnt <= 0. The lemming falls through and fills the pit.
  2. Dig: else if digging, dig_cnt increments. When dig_cnt == DIG_CYCLES-1, depth[pos] <= DIG_DEPTH and dig_cnt <= 0.
  3. Move: else if walk_left xor walk_right, pos moves one column in that direction unless at the wall. At the wall pos holds and the bump output is high. step_cnt increments on actual moves only.
  4. Otherwise hold. dig_cnt <= 0 whenever digging is low.
- Fall length: fall_len increments while ground == 0, saturating at 31. On the first cycle with ground == 1, if fall_len > SPLAT_LEN then splat <= 1; fall_len <= 0 in that same cycle.
- splat stays set until reset. The model keeps running after a splat.
- Map write: depth[map_addr] <= map_wdata, except in a cycle where rule 1 or 2 writes the same column; the internal update wins. Writes with map_addr >= WIDTH are ignored.
- walk_left and walk_right both high (illegal): no move, no bump.

## Timing
- Reset values: all depth = 0, pos = START_POS, dig_cnt = 0, fall_len = 0, splat = 0, step_cnt = 0.
- Output values after reset: ground = 1, bump_left = 0, bump_right = 0 (with walk inputs low).
- Moves and new pos: new pos is visible the cycle after walk is sampled. ground and bump reflect that new pos combinationally in the same cycle.
- Fall: entering a column of depth d gives exactly d consecutive ground=0 cycles, then ground=1.
- Dig: DIG_CYCLES grounded digging cycles produce ground=0 on the next cycle, lasting DIG_DEPTH cycles.
- Reset has priority over every other action, including mid-fall and mid-dig. An in-progress pit is discarded because the map is cleared.

## Configuration
- LEMMING_WORLD_STEP_CNT_EN:
  - Defined: step_cnt counts successful moves, wraps at 2^16, and is cleared by reset.
  - Undefined: no counter register; step_cnt is driven constant 0.

## Test plan
- Reset, then walk_left held with all-zero map: pos 8→0 in 8 cycles, then bump_left=1 with pos held at 0.
- depth[6]=4, walk_left from pos 8: after the move to 6, ground=0 for exactly 4 cycles, then depth[6]=0, ground=1, splat=0.
- depth[7]=25, walk_left from 8: ground=0 for 25 cycles; fall_len reaches 25; splat=1 on the landing cycle and stays 1.
- digging held at pos 8 on flat map: after 4 cycles depth[8]=3; ground=0 for 3 cycles, then ground=1.
- map_we to column 8 in the same cycle the dig completes at column 8: depth[8]=3, the write is ignored. reset asserted mid-fall: all outputs return to reset values next cycle.
- walk_left and walk_right both high: pos unchanged, bumps 0. With LEMMING_WORLD_STEP_CNT_EN, 5 moves give step_cnt=5; without it, step_cnt=0.
